// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared definitions for the operand register file.
//               Provides the register width, the FunSel micro-operation
//               codes and the read-port source-select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    // Register and bus width. The byte operations are hard-wired to 16 bits.
    localparam int RF_WIDTH = 16;
    localparam int RF_NUM_REGS = 8;

    // FunSel micro-operation codes
    localparam logic [2:0] RF_DEC       = 3'b000; // Q <- Q - 1
    localparam logic [2:0] RF_INC       = 3'b001; // Q <- Q + 1
    localparam logic [2:0] RF_LOAD      = 3'b010; // Q <- I
    localparam logic [2:0] RF_CLR       = 3'b011; // Q <- 0
    localparam logic [2:0] RF_LDLO_CLR  = 3'b100; // Q <- {8'h00, I[7:0]}
    localparam logic [2:0] RF_WRLO      = 3'b101; // Q[7:0] <- I[7:0]
    localparam logic [2:0] RF_WRHI      = 3'b110; // Q[15:8] <- I[7:0]
    localparam logic [2:0] RF_LDLO_SEXT = 3'b111; // Q <- sign-extended I[7:0]

    // Read-port source selects
    localparam logic [2:0] SEL_R1 = 3'd0;
    localparam logic [2:0] SEL_R2 = 3'd1;
    localparam logic [2:0] SEL_R3 = 3'd2;
    localparam logic [2:0] SEL_R4 = 3'd3;
    localparam logic [2:0] SEL_S1 = 3'd4;
    localparam logic [2:0] SEL_S2 = 3'd5;
    localparam logic [2:0] SEL_S3 = 3'd6;
    localparam logic [2:0] SEL_S4 = 3'd7;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/reg16.sv
`default_nettype none
// ============================================================================
// Module      : reg16
// Description : Single 16-bit register executing one FunSel micro-operation
//               per cycle when enabled.
// Ports       : Clock  - rising-edge clock
//               Reset  - synchronous active-high clear (overrides E)
//               E      - enable; when low the register holds
//               FunSel - micro-operation code (see rf_pkg)
//               I      - write data
//               Q      - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module reg16
    import rf_pkg::*;
(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                E,
    input  logic [2:0]          FunSel,
    input  logic [RF_WIDTH-1:0] I,
    output logic [RF_WIDTH-1:0] Q
);

    logic [RF_WIDTH-1:0] r_q;
    logic [RF_WIDTH-1:0] w_next;

    // Next-value selection. Increment/decrement wrap modulo 2^16; no carry
    // leaves the register.
    always_comb begin
        w_next = r_q;
        case (FunSel)
            RF_DEC:       w_next = r_q - 16'd1;
            RF_INC:       w_next = r_q + 16'd1;
            RF_LOAD:      w_next = I;
            RF_CLR:       w_next = '0;
            RF_LDLO_CLR:  w_next = {8'h00, I[7:0]};
            RF_WRLO:      w_next = {r_q[15:8], I[7:0]};
            RF_WRHI:      w_next = {I[7:0], r_q[7:0]};
            RF_LDLO_SEXT: w_next = {{8{I[7]}}, I[7:0]};
            default:      w_next = r_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_q <= '0;
        end else if (E) begin
            r_q <= w_next;
        end
    end

    assign Q = r_q;

endmodule : reg16
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : Eight-entry operand register file (R1-R4, S1-S4) feeding the
//               ALU A/B operand buses through two independent 8:1 read muxes.
//               One shared micro-operation is applied to every selected
//               register each cycle.
// Ports       : Clock   - rising-edge clock
//               Reset   - synchronous active-high clear of all registers
//               I       - write data (ALU result / memory data)
//               FunSel  - micro-operation applied to selected registers
//               RegSel  - enables for R1..R4 (bit 0 = R1)
//               ScrSel  - enables for S1..S4 (bit 0 = S1)
//               OutASel - A-port source (0-3 = R1-R4, 4-7 = S1-S4)
//               OutBSel - B-port source, same encoding
//               OutA    - A operand bus (combinational)
//               OutB    - B operand bus (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import rf_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [3:0]       RegSel,
    input  logic [3:0]       ScrSel,
    input  logic [2:0]       OutASel,
    input  logic [2:0]       OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB
);

    // Enable index matches the read-select encoding: 0-3 = R1-R4, 4-7 = S1-S4.
    logic [RF_NUM_REGS-1:0] w_enable;
    logic [WIDTH-1:0]       w_q [RF_NUM_REGS];

    assign w_enable = {ScrSel, RegSel};

    generate
        for (genvar g = 0; g < RF_NUM_REGS; g++) begin : g_reg
            reg16 u_reg16 (
                .Clock  (Clock),
                .Reset  (Reset),
                .E      (w_enable[g]),
                .FunSel (FunSel),
                .I      (I),
                .Q      (w_q[g])
            );
        end
    endgenerate

    // Read ports show committed state only; no bypass of in-flight writes.
    assign OutA = w_q[OutASel];
    assign OutB = w_q[OutBSel];

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Directed self-checking bench for register_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;
    import rf_pkg::*;

    logic        Clock;
    logic        Reset;
    logic [15:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [15:0] OutA;
    logic [15:0] OutB;

    int checks   = 0;
    int failures = 0;

    // Distinct contents used for the port-independence sweep, index = select.
    logic [15:0] c_pat [8];

    register_file #(.WIDTH(16)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .I       (I),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .ScrSel  (ScrSel),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_value(input string tag, input logic [15:0] got,
                               input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait for the committing edge, then settle away from it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Apply one micro-operation for one cycle, then return to idle.
    task automatic apply(input logic [3:0] rsel, input logic [3:0] ssel,
                         input logic [2:0] fun, input logic [15:0] data);
        RegSel = rsel;
        ScrSel = ssel;
        FunSel = fun;
        I      = data;
        tick();
        RegSel = 4'h0;
        ScrSel = 4'h0;
    endtask

    task automatic read_a(input string tag, input logic [2:0] sel,
                          input logic [15:0] exp);
        OutASel = sel;
        #1;
        check_value(tag, OutA, exp);
    endtask

    initial begin
        Reset   = 1'b0;
        I       = 16'h0000;
        FunSel  = RF_LOAD;
        RegSel  = 4'h0;
        ScrSel  = 4'h0;
        OutASel = SEL_R1;
        OutBSel = SEL_R1;

        c_pat[0] = 16'h1A01; c_pat[1] = 16'h2B02;
        c_pat[2] = 16'h3C03; c_pat[3] = 16'h4D04;
        c_pat[4] = 16'h5E05; c_pat[5] = 16'h6F06;
        c_pat[6] = 16'h7007; c_pat[7] = 16'h8108;

        // ---------------- reset ----------------
        @(negedge Clock);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 8; k++)
            read_a($sformatf("reset reg%0d", k), 3'(k), 16'h0000);

        // ---------------- load R2, read-during-write ----------------
        OutASel = SEL_R2;
        OutBSel = SEL_R2;
        RegSel  = 4'b0010;
        FunSel  = RF_LOAD;
        I       = 16'h1234;
        #1;
        check_value("R2 load cycle A", OutA, 16'h0000);
        check_value("R2 load cycle B", OutB, 16'h0000);
        tick();
        RegSel = 4'h0;
        check_value("R2 after load A", OutA, 16'h1234);
        check_value("R2 after load B", OutB, 16'h1234);

        // ---------------- wrap-around ----------------
        apply(4'h0, 4'b1000, RF_LOAD, 16'hFFFF);
        read_a("S4 load", SEL_S4, 16'hFFFF);
        apply(4'h0, 4'b1000, RF_INC, 16'h0000);
        read_a("S4 inc wrap", SEL_S4, 16'h0000);
        apply(4'b0001, 4'h0, RF_CLR, 16'h5A5A);
        read_a("R1 clear", SEL_R1, 16'h0000);
        apply(4'b0001, 4'h0, RF_DEC, 16'h0000);
        read_a("R1 dec wrap", SEL_R1, 16'hFFFF);

        // ---------------- byte operations on R3 ----------------
        apply(4'b0100, 4'h0, RF_LOAD, 16'hABCD);
        read_a("R3 load", SEL_R3, 16'hABCD);
        apply(4'b0100, 4'h0, RF_WRLO, 16'h0012);
        read_a("R3 wrlo", SEL_R3, 16'hAB12);
        apply(4'b0100, 4'h0, RF_WRHI, 16'h0034);
        read_a("R3 wrhi", SEL_R3, 16'h3412);
        apply(4'b0100, 4'h0, RF_LDLO_CLR, 16'hFF80);
        read_a("R3 ldlo clr", SEL_R3, 16'h0080);
        apply(4'b0100, 4'h0, RF_LDLO_SEXT, 16'h0080);
        read_a("R3 sext neg", SEL_R3, 16'hFF80);
        apply(4'b0100, 4'h0, RF_LDLO_SEXT, 16'hFF7F);
        read_a("R3 sext pos", SEL_R3, 16'h007F);

        // ---------------- multi-select increment ----------------
        apply(4'b0001, 4'h0, RF_LOAD, 16'h0005);
        apply(4'h0, 4'b0001, RF_LOAD, 16'h0100);
        apply(4'b0001, 4'b0001, RF_INC, 16'hFFFF);
        read_a("multi R1", SEL_R1, 16'h0006);
        read_a("multi S1", SEL_S1, 16'h0101);
        read_a("multi R2 held", SEL_R2, 16'h1234);
        read_a("multi R3 held", SEL_R3, 16'h007F);
        read_a("multi R4 held", SEL_R4, 16'h0000);
        read_a("multi S2 held", SEL_S2, 16'h0000);
        read_a("multi S3 held", SEL_S3, 16'h0000);
        read_a("multi S4 held", SEL_S4, 16'h0000);

        // ---------------- idle cycle holds everything ----------------
        apply(4'h0, 4'h0, RF_CLR, 16'h0000);
        read_a("idle R1 held", SEL_R1, 16'h0006);
        read_a("idle R2 held", SEL_R2, 16'h1234);

        // ---------------- reset beats a global load ----------------
        Reset = 1'b1;
        apply(4'hF, 4'hF, RF_LOAD, 16'h5555);
        Reset = 1'b0;
        for (int k = 0; k < 8; k++)
            read_a($sformatf("reset over load reg%0d", k), 3'(k), 16'h0000);

        // ---------------- reset mid-count on R4 ----------------
        apply(4'b1000, 4'h0, RF_INC, 16'h0000);
        apply(4'b1000, 4'h0, RF_INC, 16'h0000);
        apply(4'b1000, 4'h0, RF_INC, 16'h0000);
        read_a("R4 count 3", SEL_R4, 16'h0003);
        Reset = 1'b1;
        apply(4'b1000, 4'h0, RF_INC, 16'h0000);
        Reset = 1'b0;
        read_a("R4 reset mid count", SEL_R4, 16'h0000);
        apply(4'b1000, 4'h0, RF_INC, 16'h0000);
        read_a("R4 restart 1", SEL_R4, 16'h0001);
        apply(4'b1000, 4'h0, RF_INC, 16'h0000);
        read_a("R4 restart 2", SEL_R4, 16'h0002);

        // ---------------- independent ports, full select sweep ----------------
        for (int k = 0; k < 4; k++) begin
            apply(4'(1 << k), 4'h0, RF_LOAD, c_pat[k]);
            apply(4'h0, 4'(1 << k), RF_LOAD, c_pat[k + 4]);
        end
        OutASel = SEL_S3;
        OutBSel = SEL_R1;
        #1;
        check_value("port A S3", OutA, 16'h7007);
        check_value("port B R1", OutB, 16'h1A01);
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                OutASel = 3'(a);
                OutBSel = 3'(b);
                #1;
                check_value($sformatf("sweep A a=%0d b=%0d", a, b), OutA, c_pat[a]);
                check_value($sformatf("sweep B a=%0d b=%0d", a, b), OutB, c_pat[b]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire
